// File: rtl/axicb_burst_arbiter_if.sv
// Requester-side and downstream-side handshake bundle for the burst arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the downstream port.
interface axicb_burst_arbiter_if #(
    parameter int unsigned REQ_NB = 4,
    parameter int unsigned PRIO_W = 2
);
    logic [REQ_NB-1:0]        req_valid;
    logic [REQ_NB-1:0]        req_last;
    logic [REQ_NB*PRIO_W-1:0] req_prio;
    logic [REQ_NB-1:0]        req_ready;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;

    modport slave (
        input  req_valid, req_last, req_prio, out_ready,
        output req_ready, out_valid, out_last
    );

    modport master (
        output req_valid, req_last, req_prio, out_ready,
        input  req_ready, out_valid, out_last
    );
endinterface

// File: rtl/axicb_burst_arbiter.sv
// Burst-granular arbiter for one shared AXI AW/W channel.
// Selection is by priority layer first, then round-robin within the layer. The grant is locked until the winner's last beat is accepted.
module axicb_burst_arbiter #(
    parameter int unsigned REQ_NB    = 4,
    parameter int unsigned PRIO_W    = 2,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      srst,
    input  logic                      en,
    axicb_burst_arbiter_if.slave      bus,
    output logic [REQ_NB-1:0]         grant,
    output logic [$clog2(REQ_NB)-1:0] grant_id,
    output logic                      busy,
    output logic                      err_overlen
);
    localparam int unsigned IDW        = $clog2(REQ_NB);
    localparam int unsigned CNT_W      = $clog2(MAX_BEATS);
    localparam int unsigned NUM_LAYERS = 1 << PRIO_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [REQ_NB-1:0]  grant_nxt;
    logic [IDW-1:0]     grant_id_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               err_nxt;
    logic [REQ_NB-1:0]  masks [NUM_LAYERS];

    logic [PRIO_W-1:0]  top_prio;
    logic [REQ_NB-1:0]  cand, cand_masked, pick_src;
    logic               pick_valid;
    logic [IDW-1:0]     pick_id;
    logic [REQ_NB-1:0]  pick_onehot;
    logic [REQ_NB-1:0]  mask_val;
    logic               mask_we;
    logic               active, beat, last_beat;

    // Combinational pick: top layer, then the lowest index past the layer's round-robin pointer
    always_comb begin
        top_prio = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (bus.req_valid[i] && (bus.req_prio[i*PRIO_W +: PRIO_W] > top_prio)) begin
                top_prio = bus.req_prio[i*PRIO_W +: PRIO_W];
            end
        end
        cand = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            cand[i] = bus.req_valid[i] && (bus.req_prio[i*PRIO_W +: PRIO_W] == top_prio);
        end
        cand_masked = cand & masks[top_prio];
        pick_src    = (|cand_masked) ? cand_masked : cand;
        pick_valid  = |cand;
        pick_id     = '0;
        for (int i = REQ_NB - 1; i >= 0; i--) begin
            if (pick_src[i]) pick_id = IDW'(i);
        end
        pick_onehot = REQ_NB'(1) << pick_id;
        mask_val    = '0;
        for (int j = 0; j < REQ_NB; j++) begin
            mask_val[j] = (j > int'(pick_id));
        end
        if (pick_id == IDW'(REQ_NB - 1)) mask_val = '1;
    end

    // A pending srst also blocks the handshake, so no transfer completes in the reset cycle
    assign active        = (state == LOCKED) && !srst;
    assign bus.out_valid = active && bus.req_valid[grant_id];
    assign bus.out_last  = active && bus.req_last[grant_id];
    assign bus.req_ready = active ? (grant & {REQ_NB{bus.out_ready}}) : '0;
    assign beat          = bus.out_valid && bus.out_ready;
    assign last_beat     = beat && bus.req_last[grant_id];

    // Next-state logic. A last beat re-arbitrates at the same edge, so back-to-back grants have no gap.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        beat_cnt_nxt = beat_cnt;
        err_nxt      = err_overlen;
        mask_we      = 1'b0;
        case (state)
            IDLE: begin
                if (en && pick_valid) begin
                    state_nxt    = LOCKED;
                    grant_nxt    = pick_onehot;
                    grant_id_nxt = pick_id;
                    mask_we      = 1'b1;
                end
            end
            LOCKED: begin
                if (last_beat) begin
                    beat_cnt_nxt = '0;
                    if (en && pick_valid) begin
                        grant_nxt    = pick_onehot;
                        grant_id_nxt = pick_id;
                        mask_we      = 1'b1;
                    end else begin
                        state_nxt    = IDLE;
                        grant_nxt    = '0;
                        grant_id_nxt = '0;
                    end
                end else if (beat) begin
                    if (beat_cnt == CNT_W'(MAX_BEATS - 1)) err_nxt = 1'b1;
                    else beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and status registers; the synchronous reset mirrors the asynchronous reset
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            err_overlen <= 1'b0;
            beat_cnt    <= '0;
            for (int l = 0; l < NUM_LAYERS; l++) masks[l] <= '1;
        end else if (srst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            err_overlen <= 1'b0;
            beat_cnt    <= '0;
            for (int l = 0; l < NUM_LAYERS; l++) masks[l] <= '1;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            busy        <= (state_nxt == LOCKED);
            err_overlen <= err_nxt;
            beat_cnt    <= beat_cnt_nxt;
            if (mask_we) masks[top_prio] <= mask_val;
        end
    end
endmodule

// File: tb/tb_axicb_burst_arbiter.sv
// Directed bench for axicb_burst_arbiter. Each scenario task checks hand-computed grants and status.
module tb_axicb_burst_arbiter;
    logic       aclk = 1'b0;
    logic       areset;
    logic       srst;
    logic       en;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_overlen;
    int         compared   = 0;
    int         mismatched = 0;

    axicb_burst_arbiter_if #(.REQ_NB(4), .PRIO_W(2)) bus ();

    axicb_burst_arbiter #(.REQ_NB(4), .PRIO_W(2), .MAX_BEATS(4)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .srst        (srst),
        .en          (en),
        .bus         (bus),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_overlen (err_overlen)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_prio  = '0;
        bus.out_ready = 1'b0;
        en            = 1'b0;
    endtask

    task automatic do_srst();
        idle_inputs();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        srst   = 1'b0;
        idle_inputs();
        tick();
        tick();
        compared++;
        if (grant !== 4'b0000 || grant_id !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_grant got=%b/%0d exp=0000/0", grant, grant_id);
        end
        compared++;
        if (busy !== 1'b0 || err_overlen !== 1'b0 || bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_status got busy=%b err=%b rdy=%b ov=%b exp=0", busy, err_overlen, bus.req_ready, bus.out_valid);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [1:0] exp_id [5];
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_srst();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.out_ready = 1'b1;
        en            = 1'b1;
        #1;
        compared++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rr_idle got=%b busy=%b exp=0000 busy=0", grant, busy);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (grant !== exp_g[c] || grant_id !== exp_id[c] || bus.req_ready !== exp_g[c] || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL rr_grant c=%0d got=%b/%0d rdy=%b busy=%b exp=%b/%0d", c, grant, grant_id, bus.req_ready, busy, exp_g[c], exp_id[c]);
            end
        end
    endtask

    task automatic test_skip_invalid();
        logic [3:0] exp_g [4];
        exp_g = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        do_srst();
        bus.req_valid = 4'b1101;
        bus.req_last  = 4'b1111;
        bus.out_ready = 1'b1;
        en            = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            compared++;
            if (grant !== exp_g[c]) begin
                mismatched++;
                $display("FAIL skip_grant c=%0d got=%b exp=%b", c, grant, exp_g[c]);
            end
        end
    endtask

    task automatic test_priority();
        do_srst();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_prio  = 8'h20;
        bus.out_ready = 1'b1;
        en            = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            compared++;
            if (grant !== 4'b0100) begin
                mismatched++;
                $display("FAIL prio_high c=%0d got=%b exp=0100", c, grant);
            end
        end
        en = 1'b0;
        tick();
        compared++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL prio_en_off got=%b busy=%b exp=0000 busy=0", grant, busy);
        end
        tick();
        compared++;
        if (grant !== 4'b0000) begin
            mismatched++;
            $display("FAIL prio_en_hold got=%b exp=0000", grant);
        end
        bus.req_valid = 4'b1011;
        bus.req_prio  = 8'h00;
        en            = 1'b1;
        tick();
        compared++;
        if (grant !== 4'b0001) begin
            mismatched++;
            $display("FAIL prio_layer0_first got=%b exp=0001", grant);
        end
        tick();
        compared++;
        if (grant !== 4'b0010) begin
            mismatched++;
            $display("FAIL prio_layer0_second got=%b exp=0010", grant);
        end
    endtask

    task automatic test_lock_hold();
        int nb;
        do_srst();
        bus.req_valid = 4'b0011;
        bus.req_last  = 4'b0000;
        en            = 1'b1;
        tick();
        #1;
        compared++;
        if (grant !== 4'b0001) begin
            mismatched++;
            $display("FAIL lock_first got=%b exp=0001", grant);
        end
        nb = 0;
        for (int c = 0; c < 7; c++) begin
            bus.out_ready = (c % 2 == 0);
            bus.req_last  = (nb == 3) ? 4'b0001 : 4'b0000;
            #1;
            compared++;
            if (grant !== 4'b0001 || bus.req_ready !== (bus.out_ready ? 4'b0001 : 4'b0000)) begin
                mismatched++;
                $display("FAIL lock_hold c=%0d got=%b rdy=%b exp=0001", c, grant, bus.req_ready);
            end
            if (bus.out_ready) nb++;
            tick();
        end
        #1;
        compared++;
        if (grant !== 4'b0010 || grant_id !== 2'd1 || err_overlen !== 1'b0) begin
            mismatched++;
            $display("FAIL lock_handoff got=%b/%0d err=%b exp=0010/1 err=0", grant, grant_id, err_overlen);
        end
    endtask

    task automatic test_overlen();
        do_srst();
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0000;
        bus.out_ready = 1'b1;
        en            = 1'b1;
        tick();
        for (int b = 1; b <= 5; b++) begin
            bus.req_last = (b == 5) ? 4'b0001 : 4'b0000;
            #1;
            compared++;
            if (err_overlen !== (b >= 5)) begin
                mismatched++;
                $display("FAIL overlen_beat b=%0d got=%b exp=%b", b, err_overlen, (b >= 5));
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        tick();
        compared++;
        if (err_overlen !== 1'b1 || busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL overlen_sticky got err=%b busy=%b ov=%b exp err=1 busy=1 ov=0", err_overlen, busy, bus.out_valid);
        end
        do_srst();
        compared++;
        if (err_overlen !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL overlen_clear got err=%b busy=%b exp 0/0", err_overlen, busy);
        end
    endtask

    task automatic test_async_reset();
        do_srst();
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0000;
        bus.out_ready = 1'b1;
        en            = 1'b1;
        tick();
        tick();
        #2;
        compared++;
        if (bus.req_ready !== 4'b0001) begin
            mismatched++;
            $display("FAIL areset_pre got rdy=%b exp=0001", bus.req_ready);
        end
        areset = 1'b1;
        #1;
        compared++;
        if (grant !== 4'b0000 || bus.req_ready !== 4'b0000 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL areset_async got g=%b rdy=%b busy=%b ov=%b exp 0", grant, bus.req_ready, busy, bus.out_valid);
        end
        #1;
        areset        = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        tick();
        compared++;
        if (grant !== 4'b0001) begin
            mismatched++;
            $display("FAIL areset_restart got=%b exp=0001", grant);
        end
        tick();
        compared++;
        if (grant !== 4'b0010) begin
            mismatched++;
            $display("FAIL areset_next got=%b exp=0010", grant);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_skip_invalid();
        test_priority();
        test_lock_hold();
        test_overlen();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end
endmodule
